img_stream_proc: RTL

Parametrised, runtime-configurable pixel-stream processor for the CMOS→SDRAM→VGA path. It accepts an RGB565 sop/eop/vld stream and emits an RGB565 stream in one of four modes: passthrough, gray, binary, or inverted binary. All modes have the same fixed latency. Mode and threshold change only on frame boundaries, and the block checks frame protocol and frame length. It sits between the capture-side stream and the SDRAM write side, as a selectable replacement for the fixed gray→binary chain.

---
 rtl/img_stream_if.sv | 25 ++
 rtl/img_stream_proc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_if.sv
// -----------------------------------------------------------------------------
// img_stream_if
//
// One RGB565 pixel stream with sop/eop/vld framing. There is no backpressure:
// a beat is transferred in every cycle in which vld is high.
//
// Signals:
//   sop  - first pixel of a frame, qualified by vld
//   eop  - last pixel of a frame, qualified by vld
//   vld  - pixel valid
//   data - RGB565 pixel {R5, G6, B5}
//
// Modports:
//   master - drives the stream
//   slave  - receives the stream
// -----------------------------------------------------------------------------
interface img_stream_if;
    logic        sop;
    logic        eop;
    logic        vld;
    logic [15:0] data;

    modport master (output sop, output eop, output vld, output data);
    modport slave  (input  sop, input  eop, input  vld, input  data);
endinterface : img_stream_if

// File: rtl/img_stream_proc.sv
// -----------------------------------------------------------------------------
// img_stream_proc
//
// Runtime-configurable RGB565 pixel-stream processor. Each accepted pixel is
// passed through unchanged, converted to gray, or thresholded to a binary or
// inverted-binary pixel. Every mode has the same 3-cycle latency, and one
// pixel can be accepted in every clock.
//
// A frame starts on a sop beat. cfg_mode and cfg_thr are sampled on that beat
// and then held for the whole frame. Beats outside a frame are dropped. The
// block also checks the frame protocol (sop inside a frame) and the frame
// length (IMG_W*IMG_H pixels).
//
// Ports:
//   clk       - single clock
//   rst_n     - asynchronous active-low reset
//   cfg_mode  - requested mode: 0 passthrough, 1 gray, 2 binary, 3 inv binary
//   cfg_thr   - requested binary threshold
//   din       - input stream (slave)
//   dout      - output stream (master), 3 cycles after the input beat
//   act_mode  - mode latched for the current or most recent frame
//   frame_cnt - number of completed frames, wraps at its maximum
//   err_sop   - sticky: a sop arrived inside a frame
//   err_len   - sticky: a frame ended with a pixel count other than IMG_W*IMG_H
// -----------------------------------------------------------------------------
module img_stream_proc #(
    parameter int         IMG_W        = 640,
    parameter int         IMG_H        = 480,
    parameter logic [1:0] DEFAULT_MODE = 2'd2,
    parameter logic [7:0] DEFAULT_THR  = 8'd128,
    parameter int         FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cfg_mode,
    input  logic [7:0]        cfg_thr,
    img_stream_if.slave       din,
    img_stream_if.master      dout,
    output logic [1:0]        act_mode,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_sop,
    output logic              err_len
);

    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        S_IDLE,
        S_IN_FRAME
    } state_t;

    typedef enum logic [1:0] {
        M_PASS = 2'd0,
        M_GRAY = 2'd1,
        M_BIN  = 2'd2,
        M_INV  = 2'd3
    } mode_t;

    // -------------------------------------------------------------------------
    // Frame tracking
    // -------------------------------------------------------------------------
    state_t           state;
    logic [7:0]       thr_r;
    logic [CNT_W-1:0] pix_cnt;

    logic             start;     // sop beat: opens or restarts a frame
    logic             accept;    // beat that belongs to a frame
    logic [CNT_W-1:0] cnt_next;  // pixel count including the current beat
    logic             len_bad;
    logic [1:0]       pix_mode;  // settings this beat is processed with
    logic [7:0]       pix_thr;

    // NOTE: every signal assigned in an always_comb gets a default value at
    // the top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        start    = 1'b0;
        accept   = 1'b0;
        cnt_next = pix_cnt;
        pix_mode = act_mode;
        pix_thr  = thr_r;

        start  = din.vld & din.sop;
        accept = din.vld & (din.sop | (state == S_IN_FRAME));

        if (start) begin
            cnt_next = CNT_ONE;
            pix_mode = cfg_mode;
            pix_thr  = cfg_thr;
        end else if (pix_cnt != CNT_MAX) begin
            cnt_next = pix_cnt + CNT_ONE;
        end
    end

    assign len_bad = (cnt_next != CNT_FRAME);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            act_mode  <= DEFAULT_MODE;
            thr_r     <= DEFAULT_THR;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            err_sop   <= 1'b0;
            err_len   <= 1'b0;
        end else if (accept) begin
            pix_cnt <= cnt_next;

            if (start) begin
                act_mode <= cfg_mode;
                thr_r    <= cfg_thr;
                if (state == S_IN_FRAME) begin
                    err_sop <= 1'b1;
                end
            end

            // A sop+eop beat is a complete one-pixel frame and leaves the
            // FSM in IDLE; a plain sop opens (or re-opens) a frame.
            if (din.eop) begin
                state     <= S_IDLE;
                frame_cnt <= frame_cnt + 1'b1;
                if (len_bad) begin
                    err_len <= 1'b1;
                end
            end else if (start) begin
                state <= S_IN_FRAME;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: channel expansion to 8 bits and weighted products
    // -------------------------------------------------------------------------
    logic [7:0] r8, g8, b8;

    always_comb begin
        r8 = {din.data[15:11], din.data[15:13]};
        g8 = {din.data[10:5],  din.data[10:9]};
        b8 = {din.data[4:0],   din.data[4:2]};
    end

    logic        s1_vld, s1_sop, s1_eop;
    logic [15:0] s1_data;
    logic [1:0]  s1_mode;
    logic [7:0]  s1_thr;
    logic [15:0] s1_pr, s1_pg, s1_pb;

    // NOTE: the pipeline data registers are reset along with the valids so
    // dout reads 0 out of reset; they are plain flops, not a memory array,
    // so the reset costs nothing in RAM inference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sop  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_data <= '0;
            s1_mode <= '0;
            s1_thr  <= '0;
            s1_pr   <= '0;
            s1_pg   <= '0;
            s1_pb   <= '0;
        end else begin
            s1_vld <= accept;
            s1_sop <= accept & din.sop;
            s1_eop <= accept & din.eop;
            // Data only loads on accepted beats so dropped pixels never leak
            // into the pipeline and dout holds still between pixels.
            if (accept) begin
                s1_data <= din.data;
                s1_mode <= pix_mode;
                s1_thr  <= pix_thr;
                s1_pr   <= 16'd77  * {8'd0, r8};
                s1_pg   <= 16'd150 * {8'd0, g8};
                s1_pb   <= 16'd29  * {8'd0, b8};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: sum and shift to an 8-bit gray level
    // -------------------------------------------------------------------------
    logic [15:0] s1_sum;
    assign s1_sum = s1_pr + s1_pg + s1_pb;  // weights sum to 256: no overflow

    logic        s2_vld, s2_sop, s2_eop;
    logic [15:0] s2_data;
    logic [1:0]  s2_mode;
    logic [7:0]  s2_thr;
    logic [7:0]  s2_gray;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sop  <= 1'b0;
            s2_eop  <= 1'b0;
            s2_data <= '0;
            s2_mode <= '0;
            s2_thr  <= '0;
            s2_gray <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_sop <= s1_sop;
            s2_eop <= s1_eop;
            if (s1_vld) begin
                s2_data <= s1_data;
                s2_mode <= s1_mode;
                s2_thr  <= s1_thr;
                s2_gray <= s1_sum[15:8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: mode mux into the output registers
    // -------------------------------------------------------------------------
    logic [15:0] bin_pix;
    logic [15:0] out_pix;

    always_comb begin
        bin_pix = (s2_gray >= s2_thr) ? 16'hFFFF : 16'h0000;
        out_pix = s2_data;
        case (mode_t'(s2_mode))
            M_PASS:  out_pix = s2_data;
            M_GRAY:  out_pix = {s2_gray[7:3], s2_gray[7:2], s2_gray[7:3]};
            M_BIN:   out_pix = bin_pix;
            M_INV:   out_pix = ~bin_pix;
            default: out_pix = s2_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout.vld  <= 1'b0;
            dout.sop  <= 1'b0;
            dout.eop  <= 1'b0;
            dout.data <= '0;
        end else begin
            dout.vld <= s2_vld;
            dout.sop <= s2_sop;
            dout.eop <= s2_eop;
            if (s2_vld) begin
                dout.data <= out_pix;
            end
        end
    end

endmodule : img_stream_proc
